fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//   Instruction-fetch program counter for the single-cycle CPU datapath.
//   Holds the current instruction address and drives it to instruction memory.
//   Each clock it either advances sequentially or loads a branch target.
//   A branch is taken only when the control unit asserts B and the ALU zero flag Z is high.
// PARAMETERS
//   ADDR_W      32    width of the PC, branch target and output address
//   RESET_ADDR  0     PC value forced while Reset is high
//   STEP        4     byte increment per sequential fetch (32-bit instructions)
// PORTS
//   Clock   in   1       system clock, rising-edge active
//   Reset   in   1       asynchronous, active-high reset
//   B       in   1       branch instruction flag from the control unit
//   Z       in   1       zero flag from the ALU
//   B_addr  in   ADDR_W  absolute branch target address
//   addr    out  ADDR_W  current PC, driven to instruction memory
// BEHAVIOUR
//   - Clocking: one clock (Clock). Reset is asynchronous and active-high.
//   - Storage: one ADDR_W-bit PC register. addr is the register output
//     directly, with no combinational path from any input to addr.
//   - Reset: when Reset rises, the PC becomes RESET_ADDR immediately, without
//     waiting for a clock edge. While Reset is high:
//     - the PC holds RESET_ADDR on every clock edge;
//     - B, Z and B_addr are ignored.
//   - After Reset is released, the next rising Clock edge applies the
//     next-PC rule below.
//   - Next-PC rule, evaluated at each rising Clock edge:
//     - B=1 and Z=1: PC <= B_addr, taken verbatim (absolute target, no
//       offset, no alignment masking).
//     - Otherwise (B=0, or B=1 with Z=0): PC <= PC + STEP.
//   - Latency: a branch decision sampled at edge N is visible on addr right
//     after edge N. The next-PC rule has exactly one cycle of latency.
//   - Arithmetic: the increment is modulo 2^ADDR_W.
//     Example: 32'hFFFF_FFFC + 4 = 32'h0000_0000. There is no overflow flag.
//   - Z is ignored when B=0, so a Z=1 without B never redirects the PC.
//   - Simultaneous events:
//     - Reset has priority over branch and increment in all cases.
//     - B_addr may change in the same cycle as B/Z. The value present at the
//       sampling edge is the one used.
//   - Reset mid-operation: the PC returns to RESET_ADDR asynchronously, and
//     any in-flight branch is discarded.
//   - Unknown inputs: X on B or Z may propagate X into the PC. The
//     integration is responsible for ensuring B and Z are always driven.
// STRUCTURE
//   - Shared package cpu_pkg holds ADDR_W, RESET_ADDR, STEP and the
//     instruction-width constant.
//   - Optional sub-module fetch_next_pc: purely combinational adder plus 2:1
//     mux computing next_pc from pc, B, Z and B_addr.
//   - The top level then holds only the asynchronous-reset PC register.
// TESTING
//   1. Reset: with Reset=1, toggle Clock 4x -> addr=0 throughout. Assert
//      Reset mid-count with no clock -> addr=0 immediately.
//   2. Sequential fetch: Reset=0, B=0, Z=0, 4 clocks -> addr = 4, 8, 12, 16.
//   3. Taken branch: B=1, Z=1, B_addr=32'h1234abcd, 1 clock -> addr=32'h1234abcd.
//      Then B=0, 1 clock -> addr=32'h1234abd1.
//   4. Not taken: B=1, Z=0, B_addr=32'hDEAD0000 -> addr=PC+4.
//      B=0, Z=1 -> addr=PC+4.
//   5. Wrap: branch to 32'hFFFFFFFC, then B=0, 1 clock -> addr=32'h00000000.
//   6. Priority: Reset=1 with B=1, Z=1 at a clock edge -> addr=0, not B_addr.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU datapath constants: PC width, reset vector, fetch step and
// instruction width.
package cpu_pkg;

  localparam int ADDR_W = 32;
  localparam int INSTR_W = 32;
  localparam logic [ADDR_W-1:0] RESET_ADDR = '0;
  localparam int STEP = INSTR_W / 8;

endpackage : cpu_pkg

// File: rtl/fetch_unit_if.sv
// Fetch-side bus: branch control from the control unit and ALU, plus the
// current instruction address driven toward instruction memory.
interface fetch_unit_if #(
  parameter int ADDR_W = cpu_pkg::ADDR_W
);

  logic              B;
  logic              Z;
  logic [ADDR_W-1:0] B_addr;
  logic [ADDR_W-1:0] addr;

  // Control/datapath side: drives the branch request, observes the PC.
  modport master (
    output B,
    output Z,
    output B_addr,
    input  addr
  );

  // Fetch unit side: consumes the branch request, drives the PC.
  modport slave (
    input  B,
    input  Z,
    input  B_addr,
    output addr
  );

endinterface : fetch_unit_if

// File: rtl/fetch_next_pc.sv
// Next-PC selection: a sequential increment (wrapping modulo 2^ADDR_W)
// or an absolute branch target when both B and Z are set.
module fetch_next_pc
  import cpu_pkg::*;
#(
  parameter int ADDR_W = cpu_pkg::ADDR_W,
  parameter int STEP   = cpu_pkg::STEP
) (
  input  logic [ADDR_W-1:0] pc,
  input  logic              b,
  input  logic              z,
  input  logic [ADDR_W-1:0] b_addr,
  output logic [ADDR_W-1:0] next_pc
);

  logic [ADDR_W-1:0] seq_pc;
  logic              take_branch;

  // The carry out of the adder is dropped on purpose so the PC wraps.
  assign seq_pc      = pc + ADDR_W'(STEP);
  // Z only matters for a branch instruction.
  assign take_branch = b & z;

  // Branch target is used verbatim: no offset and no alignment masking.
  always_comb begin
    next_pc = seq_pc;
    if (take_branch) begin
      next_pc = b_addr;
    end
  end

endmodule : fetch_next_pc

// File: rtl/fetch_unit.sv
// Instruction-fetch program counter. Holds the PC register and drives it
// straight to instruction memory; next-PC selection lives in fetch_next_pc.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int                ADDR_W     = cpu_pkg::ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_ADDR = cpu_pkg::RESET_ADDR,
  parameter int                STEP       = cpu_pkg::STEP
) (
  input  logic       Clock,
  input  logic       Reset,
  fetch_unit_if.slave bus
);

  logic [ADDR_W-1:0] pc_reg;
  logic [ADDR_W-1:0] pc_next;

  fetch_next_pc #(
    .ADDR_W (ADDR_W),
    .STEP   (STEP)
  ) u_next_pc (
    .pc      (pc_reg),
    .b       (bus.B),
    .z       (bus.Z),
    .b_addr  (bus.B_addr),
    .next_pc (pc_next)
  );

  // PC register: Reset forces the reset vector at once and holds it,
  // discarding any branch presented on the same edge.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      pc_reg <= RESET_ADDR;
    end else begin
      pc_reg <= pc_next;
    end
  end

  // Registered output only; no input reaches addr combinationally.
  assign bus.addr = pc_reg;

endmodule : fetch_unit

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed stimulus, a reference PC model, a
// per-cycle compare process and literal spot checks.
module tb_fetch_unit;

  logic Clock = 1'b0;
  logic Reset = 1'b0;
  int   checks = 0;
  int   errors = 0;
  bit   cmp_en = 1'b0;
  logic [31:0] model_pc = 32'h0;

  fetch_unit_if #(.ADDR_W(32)) bus ();

  fetch_unit dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus)
  );

  // 10 time-unit clock period
  always #5 Clock = ~Clock;

  // Reference model: what the PC must be, from the fetch rules directly.
  always @(posedge Reset) model_pc = 32'h0;
  always @(posedge Clock) begin
    if (Reset)                model_pc = 32'h0;
    else if (bus.B && bus.Z)  model_pc = bus.B_addr;
    else                      model_pc = model_pc + 32'd4;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: addr=%h expected=%h t=%0t", name, act, exp, $time);
    end else begin
      $display("ok   %s: addr=%h t=%0t", name, act, $time);
    end
  endtask

  // Per-cycle compare against the model, away from the active edge.
  always @(negedge Clock) begin
    if (cmp_en) check("model", bus.addr, model_pc);
  end

  // One clock with the given branch inputs, ending 1 unit after the edge.
  task automatic step(input logic b, input logic z, input logic [31:0] ba);
    bus.B = b;
    bus.Z = z;
    bus.B_addr = ba;
    @(posedge Clock);
    #1;
  endtask

  initial begin
    bus.B = 1'b0;
    bus.Z = 1'b0;
    bus.B_addr = 32'h0;
    #1 Reset = 1'b1;
    #1 check("reset_async_start", bus.addr, 32'h0);
    cmp_en = 1'b1;

    // Held in reset with a taken branch presented: Reset wins.
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b1, 32'hDEAD_BEEF);
      check("reset_hold_prio", bus.addr, 32'h0);
    end
    Reset = 1'b0;

    // Sequential fetch
    step(1'b0, 1'b0, 32'h0); check("seq_4",  bus.addr, 32'd4);
    step(1'b0, 1'b0, 32'h0); check("seq_8",  bus.addr, 32'd8);
    step(1'b0, 1'b0, 32'h0); check("seq_12", bus.addr, 32'd12);
    step(1'b0, 1'b0, 32'h0); check("seq_16", bus.addr, 32'd16);

    // Asynchronous reset between clock edges
    #3 Reset = 1'b1;
    #1 check("reset_async_mid", bus.addr, 32'h0);
    @(posedge Clock);
    #1 Reset = 1'b0;
    check("reset_mid_hold", bus.addr, 32'h0);
    step(1'b0, 1'b0, 32'h0); check("seq_after_reset", bus.addr, 32'd4);

    // Taken branch, then sequential from the target
    step(1'b1, 1'b1, 32'h1234_abcd); check("branch_taken", bus.addr, 32'h1234_abcd);
    step(1'b0, 1'b0, 32'h1234_abcd); check("after_branch", bus.addr, 32'h1234_abd1);

    // Not taken: B without Z, and Z without B
    step(1'b1, 1'b0, 32'hDEAD_0000); check("nt_b_only", bus.addr, 32'h1234_abd5);
    step(1'b0, 1'b1, 32'hDEAD_0000); check("nt_z_only", bus.addr, 32'h1234_abd9);

    // Wrap-around
    step(1'b1, 1'b1, 32'hFFFF_FFFC); check("branch_top", bus.addr, 32'hFFFF_FFFC);
    step(1'b0, 1'b0, 32'h0);         check("wrap_zero",  bus.addr, 32'h0000_0000);

    // Unaligned target taken verbatim, with B_addr changing every cycle
    step(1'b1, 1'b1, 32'h0000_0003); check("branch_unaligned", bus.addr, 32'h0000_0003);
    step(1'b1, 1'b1, 32'h8000_0001); check("branch_back2back", bus.addr, 32'h8000_0001);
    step(1'b0, 1'b0, 32'h5555_5555); check("seq_unaligned",    bus.addr, 32'h8000_0005);

    // Reset asserted with a taken branch at the edge
    Reset = 1'b1;
    step(1'b1, 1'b1, 32'hCAFE_F00D); check("reset_vs_branch", bus.addr, 32'h0);
    Reset = 1'b0;
    step(1'b0, 1'b0, 32'h0);         check("release_seq", bus.addr, 32'd4);

    @(negedge Clock);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_fetch_unit
